// File: rtl/mem_arbiter_if.sv
// Requester and memory signals around the unified-memory arbiter.
// master = arbiter side, slave = fetch/data requesters plus memory.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flush;
   logic [31:0] if_rdata;
   logic        if_ack;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic [31:0] d_rdata;
   logic        d_ack;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      input  if_req, if_addr, if_flush,
      output if_rdata, if_ack,
      input  d_req, d_we, d_addr, d_wdata, d_wstrb,
      output d_rdata, d_ack,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      output if_req, if_addr, if_flush,
      input  if_rdata, if_ack,
      output d_req, d_we, d_addr, d_wdata, d_wstrb,
      input  d_rdata, d_ack,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch (I) and data (D), one transaction at a time.
// Grant edge -> mem_req next cycle -> ready/timeout edge -> one RESP cycle carrying the ack pulse.
module mem_arbiter #(
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.master bus,
   output logic          busy,
   output logic          timeout_err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT_I = 2'd1;
   localparam logic [1:0] GNT_D = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

   logic [1:0]    state;
   logic [SW-1:0] streak;
   logic [TW-1:0] tmo_cnt;
   logic          drop;

   logic grant_d;
   logic grant_i;
   logic tmo_hit;
   logic launch;
   logic done_ok;
   logic done_abort;
   logic kill_i;

   always_comb begin
      grant_d    = bus.d_req && ((streak < STREAK_MAX) || !bus.if_req || bus.if_flush);
      grant_i    = !grant_d && bus.if_req && !bus.if_flush;
      tmo_hit    = (TIMEOUT > 0) && (tmo_cnt == TMO_LAST);
      launch     = ((state == GNT_I) || (state == GNT_D)) && !bus.mem_req;
      // mem_ready beats a timeout that lands on the same edge
      done_ok    = bus.mem_req && bus.mem_ready;
      done_abort = bus.mem_req && !bus.mem_ready && tmo_hit;
      kill_i     = drop || bus.if_flush;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         streak        <= '0;
         tmo_cnt       <= '0;
         drop          <= 1'b0;
         busy          <= 1'b0;
         timeout_err   <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wstrb <= '0;
         bus.if_ack    <= 1'b0;
         bus.d_ack     <= 1'b0;
         bus.if_rdata  <= NOP_WORD;
         bus.d_rdata   <= '0;
      end else begin
         bus.if_ack <= 1'b0;
         bus.d_ack  <= 1'b0;

         case (state)
            IDLE: begin
               if (!bus.if_req) begin
                  streak <= '0;
               end
               if (grant_d) begin
                  state         <= GNT_D;
                  busy          <= 1'b1;
                  bus.mem_we    <= bus.d_we;
                  bus.mem_addr  <= bus.d_addr;
                  bus.mem_wdata <= bus.d_wdata;
                  bus.mem_wstrb <= bus.d_we ? bus.d_wstrb : 4'h0;
                  if (bus.if_req && (streak != STREAK_MAX)) begin
                     streak <= streak + 1'b1;
                  end
               end else if (grant_i) begin
                  state         <= GNT_I;
                  busy          <= 1'b1;
                  bus.mem_we    <= 1'b0;
                  bus.mem_addr  <= bus.if_addr;
                  bus.mem_wdata <= '0;
                  bus.mem_wstrb <= 4'h0;
                  streak        <= '0;
               end
            end

            GNT_I, GNT_D: begin
               if ((state == GNT_I) && bus.if_flush) begin
                  drop <= 1'b1;
               end
               if (launch) begin
                  bus.mem_req <= 1'b1;
                  tmo_cnt     <= '0;
               end else if (done_ok || done_abort) begin
                  bus.mem_req <= 1'b0;
                  state       <= RESP;
                  if (done_abort) begin
                     timeout_err <= 1'b1;
                  end
                  if (state == GNT_I) begin
                     // a fetch flushed at any point of its access is completed silently
                     if (!kill_i) begin
                        bus.if_ack   <= 1'b1;
                        bus.if_rdata <= done_ok ? bus.mem_rdata : NOP_WORD;
                     end
                  end else begin
                     bus.d_ack <= 1'b1;
                     if (!bus.mem_we) begin
                        bus.d_rdata <= done_ok ? bus.mem_rdata : 32'h0;
                     end
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               drop    <= 1'b0;
               tmo_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction-level bench for mem_arbiter; the bench plays both requesters and the memory.
module tb_mem_arbiter;
   localparam int MAXS = 4;
   localparam int TMO  = 8;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic reset;
   logic busy;
   logic timeout_err;

   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem_model [logic [31:0]];

   // pending requester state and expected architectural outputs
   logic        i_pend, d_pend, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_wstrb;
   int          streak;
   logic [31:0] exp_if_rdata, exp_d_rdata;
   logic        exp_terr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] strb);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] rand_addr();
      return 32'h0000_1000 + 32'($urandom_range(0, 15)) * 4;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_round();
      int          gnt;
      int          lat;
      int          r;
      logic        flush_idle, flushed, aborted, is_wr;
      logic [31:0] ea, exp_data;
      logic        exp_iack, exp_dack;

      if (!i_pend && $urandom_range(0, 9) < 7) begin
         i_pend = 1'b1;
         i_addr = rand_addr();
      end
      if (!d_pend && $urandom_range(0, 9) < 7) begin
         d_pend  = 1'b1;
         d_we    = 1'($urandom_range(0, 1));
         d_addr  = rand_addr();
         d_wdata = $urandom();
         d_wstrb = 4'($urandom_range(1, 15));
      end
      flush_idle = i_pend && ($urandom_range(0, 7) == 0);

      // D wins unless it has used up its streak against a live fetch
      gnt = 0;
      if (d_pend && (streak < MAXS || !i_pend || flush_idle)) gnt = 2;
      else if (i_pend && !flush_idle) gnt = 1;
      if (!i_pend) streak = 0;
      else if (gnt == 2) streak = (streak < MAXS) ? streak + 1 : MAXS;
      else if (gnt == 1) streak = 0;

      bus.if_req   = i_pend;
      bus.if_addr  = i_addr;
      bus.if_flush = flush_idle;
      bus.d_req    = d_pend;
      bus.d_we     = d_we;
      bus.d_addr   = d_addr;
      bus.d_wdata  = d_wdata;
      bus.d_wstrb  = d_wstrb;
      step();
      bus.if_flush = 1'b0;

      check("grant_busy", busy, (gnt != 0));
      check("grant_mem_req", bus.mem_req, 1'b0);
      if (gnt == 0) return;

      is_wr = (gnt == 2) && d_we;
      ea    = (gnt == 1) ? i_addr : d_addr;
      check("mem_addr", bus.mem_addr, ea);
      check("mem_we", bus.mem_we, is_wr);
      check("mem_wstrb", bus.mem_wstrb, is_wr ? d_wstrb : 4'h0);
      if (is_wr) check("mem_wdata", bus.mem_wdata, d_wdata);

      flushed = (gnt == 1) && ($urandom_range(0, 3) == 0);
      bus.if_flush = flushed;

      r = $urandom_range(0, 19);
      if (r < 2) lat = $urandom_range(TMO, TMO + 2);
      else if (r == 2) lat = TMO - 1;
      else lat = $urandom_range(0, 3);

      step();
      bus.if_flush = 1'b0;
      for (int k = 0; k < TMO; k++) begin
         check("mem_req_held", bus.mem_req, 1'b1);
         if (k == lat) begin
            check("mem_addr_held", bus.mem_addr, ea);
            bus.mem_ready = 1'b1;
            bus.mem_rdata = mem_rd(bus.mem_addr);
         end
         step();
         bus.mem_ready = 1'b0;
         if (k == lat) break;
      end

      aborted  = (lat >= TMO);
      exp_data = aborted ? ((gnt == 1) ? NOP : 32'h0) : mem_rd(ea);
      if (aborted) exp_terr = 1'b1;
      exp_iack = 1'b0;
      exp_dack = 1'b0;
      if (gnt == 1) begin
         if (flushed) begin
            i_addr = rand_addr();
         end else begin
            exp_iack     = 1'b1;
            exp_if_rdata = exp_data;
            i_pend       = 1'b0;
         end
      end else begin
         exp_dack = 1'b1;
         if (!d_we) exp_d_rdata = exp_data;
         else if (!aborted) mem_model[d_addr] = merge(mem_rd(d_addr), d_wdata, d_wstrb);
         d_pend = 1'b0;
      end

      check("resp_mem_req", bus.mem_req, 1'b0);
      check("resp_busy", busy, 1'b1);
      check("if_ack", bus.if_ack, exp_iack);
      check("d_ack", bus.d_ack, exp_dack);
      check("if_rdata", bus.if_rdata, exp_if_rdata);
      check("d_rdata", bus.d_rdata, exp_d_rdata);
      check("timeout_err", timeout_err, exp_terr);

      // a late mem_ready after an abort must be ignored
      if (aborted) begin
         bus.mem_ready = 1'b1;
         bus.mem_rdata = 32'hBAD0_BAD0;
      end
      step();
      bus.mem_ready = 1'b0;

      check("idle_busy", busy, 1'b0);
      check("idle_if_ack", bus.if_ack, 1'b0);
      check("idle_d_ack", bus.d_ack, 1'b0);
      check("idle_mem_req", bus.mem_req, 1'b0);
      check("idle_if_rdata", bus.if_rdata, exp_if_rdata);
      check("idle_d_rdata", bus.d_rdata, exp_d_rdata);
   endtask

   initial begin
      reset         = 1'b1;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.if_flush  = 1'b0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.d_wstrb   = '0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      i_pend = 1'b0; d_pend = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
      streak = 0;
      exp_if_rdata = NOP;
      exp_d_rdata  = '0;
      exp_terr     = 1'b0;

      step();
      step();
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_if_ack", bus.if_ack, 1'b0);
      check("rst_d_ack", bus.d_ack, 1'b0);
      check("rst_if_rdata", bus.if_rdata, NOP);
      check("rst_d_rdata", bus.d_rdata, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_timeout_err", timeout_err, 1'b0);
      reset = 1'b0;

      for (int n = 0; n < 400; n++) run_round();

      // reset in the middle of an access drops mem_req immediately
      bus.if_req  = 1'b0;
      bus.if_flush = 1'b0;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h0000_2000;
      step();
      step();
      check("mid_mem_req", bus.mem_req, 1'b1);
      reset = 1'b1;
      step();
      check("mid_rst_mem_req", bus.mem_req, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_d_ack", bus.d_ack, 1'b0);
      check("mid_rst_timeout_err", timeout_err, 1'b0);
      check("mid_rst_if_rdata", bus.if_rdata, NOP);
      reset     = 1'b0;
      bus.d_req = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
